booth_mult_arbiter: RTL and testbench

Shares one radix-2 Booth multiplier (datapath plus its 24-state sequencer) between N_REQ requesters. The block:
- grants requesters round-robin and latches the granted operands;
- pulses the multiplier's start and collects the two-word product during the multiplier's two done cycles;
- returns the signed product with a valid/ready handshake;
- recovers from a hung multiplier via a timeout that resets the multiplier.

---
 rtl/booth_mult_arbiter.sv | 140 ++++++++++++++
 tb/tb_booth_mult_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_arbiter.sv
// rtl/booth_mult_arbiter.sv - round-robin arbiter sharing one Booth multiplier between requesters
module booth_mult_arbiter #(
    parameter int N_REQ   = 4,
    parameter int W       = 5,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 63
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] x_in,
    input  logic [N_REQ*W-1:0] y_in,
    output logic [N_REQ-1:0]   gnt,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [2*W-1:0]     rsp_prod,
    output logic               rsp_err,
    output logic               busy,
    output logic               mul_start,
    output logic               mul_rst,
    output logic [W-1:0]       mul_x,
    output logic [W-1:0]       mul_y,
    input  logic               mul_done,
    input  logic [W-1:0]       mul_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CAPL,
        S_ABORT,
        S_RESP
    } state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [7:0]      cnt;

    logic [W-1:0]    xs [N_REQ];
    logic [W-1:0]    ys [N_REQ];
    logic            found;
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] cand;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign xs[i] = x_in[i*W +: W];
        assign ys[i] = y_in[i*W +: W];
    end

    // Round-robin pick: scan from ptr+1 downwards in priority so the nearest
    // requester after the last winner is the final assignment.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = ID_W'((int'(ptr) + k) % N_REQ);
            if (req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // The multiplier is held in reset with the arbiter and pulsed on abort.
    assign mul_rst = ~rst | (state == S_ABORT);
    assign busy    = (state != S_IDLE);

    // Main sequencer: grant, launch, collect both product words, respond.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            ptr       <= ID_W'(N_REQ - 1);
            cnt       <= '0;
            gnt       <= '0;
            mul_start <= 1'b0;
            mul_x     <= '0;
            mul_y     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_prod  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            gnt       <= '0;
            mul_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        mul_x     <= xs[pick];
                        mul_y     <= ys[pick];
                        rsp_id    <= pick;
                        ptr       <= pick;
                        gnt       <= N_REQ'(1) << pick;
                        mul_start <= 1'b1;
                        state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (mul_done) begin
                        rsp_prod[2*W-1:W] <= mul_out;
                        state             <= S_CAPL;
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        state <= S_ABORT;
                    end
                end
                S_CAPL: begin
                    if (mul_done) begin
                        rsp_prod[W-1:0] <= mul_out;
                        rsp_err         <= 1'b0;
                        rsp_valid       <= 1'b1;
                        state           <= S_RESP;
                    end else begin
                        state <= S_ABORT;
                    end
                end
                S_ABORT: begin
                    rsp_prod  <= '0;
                    rsp_err   <= 1'b1;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// tb/tb_booth_mult_arbiter.sv - self-checking bench for booth_mult_arbiter
module tb_booth_mult_arbiter;
    localparam int N = 4;
    localparam int W = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N*W-1:0] x_in = '0;
    logic [N*W-1:0] y_in = '0;
    logic [N-1:0]  gnt;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [1:0]    rsp_id;
    logic [2*W-1:0] rsp_prod;
    logic          rsp_err;
    logic          busy;
    logic          mul_start;
    logic          mul_rst;
    logic [W-1:0]  mul_x;
    logic [W-1:0]  mul_y;
    logic          mul_done;
    logic [W-1:0]  mul_out;

    booth_mult_arbiter #(.N_REQ(4), .W(5), .ID_W(2), .TIMEOUT(63)) dut (
        .clk(clk), .rst(rst), .req(req), .x_in(x_in), .y_in(y_in), .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_prod(rsp_prod), .rsp_err(rsp_err), .busy(busy),
        .mul_start(mul_start), .mul_rst(mul_rst), .mul_x(mul_x), .mul_y(mul_y),
        .mul_done(mul_done), .mul_out(mul_out)
    );

    always #5 clk = ~clk;

    // Mock multiplier: done on the 22nd and 23rd cycles after start.
    // mode 0 normal, 1 never done, 2 single done cycle.
    int         mode = 0;
    logic       m_active = 1'b0;
    logic [7:0] m_cnt = '0;
    logic [9:0] m_prod = '0;

    always @(posedge clk) begin
        if (mul_rst) begin
            m_active <= 1'b0;
            m_cnt    <= '0;
        end else if (mul_start) begin
            m_active <= 1'b1;
            m_cnt    <= 8'd1;
            m_prod   <= {{5{mul_x[4]}}, mul_x} * {{5{mul_y[4]}}, mul_y};
        end else if (m_active) begin
            m_cnt <= m_cnt + 8'd1;
            if (m_cnt == 8'd23) m_active <= 1'b0;
        end
    end

    always_comb begin
        mul_done = 1'b0;
        if (m_active && mode != 1) begin
            if (m_cnt == 8'd22) mul_done = 1'b1;
            if (m_cnt == 8'd23 && mode == 0) mul_done = 1'b1;
        end
        mul_out = (m_cnt == 8'd22) ? m_prod[9:5] : m_prod[4:0];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [1:0] id;
        logic [9:0] prod;
        logic       err;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_rsp = 0;
    int   cyc = 0;
    int   t_start = 0;
    int   lat = 0;
    logic prev_v = 1'b0;

    always @(posedge clk) cyc++;

    // Scoreboard: every accepted response is compared with the oldest expectation.
    always @(negedge clk) begin
        rsp_t e;
        if (mul_start) t_start = cyc;
        if (rsp_valid && !prev_v) lat = cyc - t_start;
        prev_v = rsp_valid;
        if (rst && rsp_valid && rsp_ready) begin
            n_rsp++;
            check("rsp_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_prod", 32'(rsp_prod), 32'(e.prod));
                check("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic set_ops(input int id, input logic [4:0] x, input logic [4:0] y);
        x_in[id*W +: W] = x;
        y_in[id*W +: W] = y;
    endtask

    task automatic wait_gnt;
        int n = 0;
        do begin
            tick;
            n++;
        end while (gnt == '0 && n < 100);
        check("gnt_seen", 32'(gnt != '0), 1);
    endtask

    task automatic wait_rsp(input int target);
        int n = 0;
        while (n_rsp < target && n < 200) begin
            tick;
            n++;
        end
        check("rsp_count", n_rsp, target);
    endtask

    task automatic issue(input int id, input logic [4:0] x, input logic [4:0] y,
                         input logic [9:0] prod, input logic err, input bit push);
        set_ops(id, x, y);
        req[id] = 1'b1;
        wait_gnt();
        check("gnt_onehot", 32'(gnt), 32'(4'b0001 << id));
        req[id] = 1'b0;
        if (push) exp_q.push_back(rsp_t'{2'(id), prod, err});
    endtask

    typedef struct {
        int         id;
        logic [4:0] x;
        logic [4:0] y;
        logic [9:0] prod;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int base;
        int n;

        vecs[0] = '{1, 5'd7,  5'd9,  10'h03F};
        vecs[1] = '{2, 5'h10, 5'h10, 10'h100};
        vecs[2] = '{3, 5'h10, 5'h0F, 10'h310};
        vecs[3] = '{0, 5'd0,  5'h1F, 10'h000};
        vecs[4] = '{2, 5'h0F, 5'h0F, 10'h0E1};
        vecs[5] = '{1, 5'h1F, 5'h1F, 10'h001};

        // Reset state
        #1;
        check("reset_outputs", 32'({gnt, rsp_valid, rsp_id, rsp_prod, rsp_err, mul_start, mul_x, mul_y, busy}), 0);
        check("reset_mul_rst", 32'(mul_rst), 1);
        tick;
        tick;
        rst = 1'b1;
        #1;
        check("mul_rst_released", 32'(mul_rst), 0);

        // Single request with latency
        base = n_rsp;
        issue(0, 5'b00011, 5'b11110, 10'b1111111010, 1'b0, 1'b1);
        wait_rsp(base + 1);
        check("latency", lat, 24);

        // Table of single-requester products
        for (int i = 0; i < 6; i++) begin
            base = n_rsp;
            issue(vecs[i].id, vecs[i].x, vecs[i].y, vecs[i].prod, 1'b0, 1'b1);
            wait_rsp(base + 1);
        end

        // Backpressure: response held while rsp_ready is low
        rsp_ready = 1'b0;
        base = n_rsp;
        issue(0, 5'd2, 5'd3, 10'd6, 1'b0, 1'b1);
        n = 0;
        while (!rsp_valid && n < 60) begin
            tick;
            n++;
        end
        check("bp_valid_rise", 32'(rsp_valid), 1);
        set_ops(2, 5'd1, 5'h1D);
        req[2] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check("bp_hold", 32'({rsp_valid, rsp_id, rsp_prod, rsp_err, gnt}),
                  32'({1'b1, 2'd0, 10'd6, 1'b0, 4'b0000}));
            tick;
        end
        rsp_ready = 1'b1;
        check("bp_no_gnt_resp", 32'(gnt), 0);
        tick;
        check("bp_no_gnt_idle", 32'(gnt), 0);
        tick;
        check("bp_gnt_after", 32'(gnt), 32'(4'b0100));
        req[2] = 1'b0;
        exp_q.push_back(rsp_t'{2'd2, 10'h3FD, 1'b0});
        wait_rsp(base + 2);

        // Timeout: multiplier never signals done
        mode = 1;
        base = n_rsp;
        issue(1, 5'd3, 5'd3, 10'd0, 1'b1, 1'b1);
        n = 0;
        do begin
            tick;
            n++;
        end while (!mul_rst && n < 200);
        check("timeout_delay", n, 64);
        tick;
        check("timeout_pulse_end", 32'({mul_rst, rsp_valid, rsp_err}), 32'(3'b011));
        wait_rsp(base + 1);
        mode = 0;

        // Short done: only the high word arrives
        mode = 2;
        base = n_rsp;
        issue(3, 5'd1, 5'd1, 10'd0, 1'b1, 1'b1);
        n = 0;
        do begin
            tick;
            n++;
        end while (!mul_rst && n < 200);
        check("short_done_delay", n, 24);
        wait_rsp(base + 1);
        mode = 0;

        // Reset in the middle of WAIT
        issue(2, 5'd2, 5'd2, 10'd4, 1'b0, 1'b0);
        repeat (5) tick;
        check("mid_busy", 32'(busy), 1);
        rst = 1'b0;
        #1;
        check("mid_rst_outputs", 32'({gnt, rsp_valid, rsp_id, rsp_prod, rsp_err, mul_start, mul_x, mul_y, busy}), 0);
        check("mid_rst_mul_rst0", 32'(mul_rst), 1);
        tick;
        check("mid_rst_mul_rst1", 32'(mul_rst), 1);
        tick;
        check("mid_rst_mul_rst2", 32'(mul_rst), 1);
        rst = 1'b1;
        base = n_rsp;
        repeat (40) tick;
        check("mid_rst_no_rsp", n_rsp, base);

        // All four requesters held: strict round robin starting at 0
        for (int i = 0; i < 4; i++) set_ops(i, 5'(i + 1), 5'd2);
        req = 4'b1111;
        base = n_rsp;
        for (int g = 0; g < 5; g++) begin
            wait_gnt();
            check("rr_gnt", 32'(gnt), 32'(4'b0001 << (g % 4)));
            exp_q.push_back(rsp_t'{2'(g % 4), 10'(2 * ((g % 4) + 1)), 1'b0});
            if (g == 4) req = '0;
        end
        wait_rsp(base + 5);

        repeat (5) tick;
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
